pulse_interval_monitor: RTL and testbench

- Receive-side companion to the on-chip random pulse source.
- Takes the single-bit pulse stream on an input pin, synchronises it and detects rising edges.
- Measures the clock-cycle interval between consecutive pulses and keeps last, min and max interval statistics plus a pulse count.
- Statistics are read out through a simple request/acknowledge register port for characterising the generator's randomness.

---
 rtl/pulse_mon_pkg.sv | 19 +
 rtl/pulse_interval_monitor_if.sv | 14 +
 rtl/pulse_sync_edge.sv | 37 +++
 rtl/pulse_interval_monitor.sv | 192 +++++++++++++++++++
 tb/tb_pulse_interval_monitor.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_mon_pkg.sv
// Shared types and constants for the pulse interval monitor: FSM states,
// read-select codes and default widths.
package pulse_mon_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam logic [1:0] SEL_LAST = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_MAX  = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int PCNT_W          = 8;

endpackage

// File: rtl/pulse_interval_monitor_if.sv
// Request/acknowledge statistics read port of the pulse interval monitor.
interface pulse_interval_monitor_if #(
  parameter int CNT_W = 16
);

  logic             rd_req;
  logic [1:0]       rd_sel;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_req, output rd_sel, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_sel, output rd_ack, output rd_data);

endinterface

// File: rtl/pulse_sync_edge.sv
// Input synchroniser chain plus history flop; emits a registered one-cycle
// strobe for every rising edge seen on the synchronised pulse.
module pulse_sync_edge
  import pulse_mon_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic det_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   det_q;
  logic                   edge_s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pulse_i};
  assign edge_s = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign det_o  = det_q;

  // synchroniser shift, edge history and strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      hist_q <= 1'b0;
      det_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STAGES-1];
      det_q  <= edge_s;
    end
  end

endmodule

// File: rtl/pulse_interval_monitor.sv
// Measures clock-cycle intervals between synchronised pulse edges, keeps
// last/min/max/count statistics and serves them through a req/ack read port.
module pulse_interval_monitor
  import pulse_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pulse_in,
  input  logic                     clear,
  pulse_interval_monitor_if.slave  rd,
  output logic                     pulse_det,
  output logic [PCNT_W-1:0]        pulse_cnt,
  output logic                     overflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              ovf_q, ovf_d;
  logic              rd_ack_q, rd_ack_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  logic              det_s;
  logic              run_s;
  logic              count_s;
  logic              record_s;
  logic [CNT_W:0]    sum_s;
  logic [CNT_W-1:0]  interval_s;

  // Status word: pulse count zero-extended, overflow flag in the top bit.
  function automatic logic [CNT_W-1:0] stat_word(input logic ovf,
                                                 input logic [PCNT_W-1:0] cnt);
    logic [CNT_W-1:0] w;
    w = CNT_W'(cnt);
    w[CNT_W-1] = ovf;
    return w;
  endfunction

  pulse_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .pulse_i (pulse_in),
    .det_o   (det_s)
  );

  assign sum_s      = {1'b0, cnt_q} + {1'b0, CNT_ONE};
  assign interval_s = sum_s[CNT_W] ? CNT_ONES : sum_s[CNT_W-1:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: clear dominates, any edge leaves IDLE
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (det_s) begin
      state_d = MEASURE;
    end else begin
      state_d = state_q;
    end
  end

  // FSM outputs: an edge in IDLE is only counted, in MEASURE it also closes an interval
  always_comb begin
    run_s    = 1'b0;
    count_s  = 1'b0;
    record_s = 1'b0;
    case (state_q)
      IDLE: begin
        count_s = det_s & ~clear;
      end
      MEASURE: begin
        run_s    = 1'b1;
        count_s  = det_s & ~clear;
        record_s = det_s & ~clear;
      end
      default: begin
        run_s    = 1'b0;
        count_s  = 1'b0;
        record_s = 1'b0;
      end
    endcase
  end

  // statistics and interval counter next values
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    pcnt_d = pcnt_q;
    ovf_d  = ovf_q;
    if (clear) begin
      cnt_d  = CNT_ZERO;
      last_d = CNT_ZERO;
      min_d  = CNT_ONES;
      max_d  = CNT_ZERO;
      pcnt_d = {PCNT_W{1'b0}};
      ovf_d  = 1'b0;
    end else begin
      if (det_s) begin
        cnt_d = CNT_ZERO;
      end else if (run_s && (cnt_q != CNT_ONES)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
      if (count_s) begin
        pcnt_d = pcnt_q + {{(PCNT_W-1){1'b0}}, 1'b1};
      end else begin
        pcnt_d = pcnt_q;
      end
      if (record_s) begin
        last_d = interval_s;
        min_d  = (interval_s < min_q) ? interval_s : min_q;
        max_d  = (interval_s > max_q) ? interval_s : max_q;
        ovf_d  = ovf_q | sum_s[CNT_W];
      end else begin
        last_d = last_q;
        min_d  = min_q;
        max_d  = max_q;
        ovf_d  = ovf_q;
      end
    end
  end

  // read port: snapshot of the registered statistics, one ack per request
  always_comb begin
    rd_ack_d  = rd.rd_req;
    rd_data_d = rd_data_q;
    if (rd.rd_req) begin
      case (rd.rd_sel)
        SEL_LAST: rd_data_d = last_q;
        SEL_MIN:  rd_data_d = min_q;
        SEL_MAX:  rd_data_d = max_q;
        SEL_STAT: rd_data_d = stat_word(ovf_q, pcnt_q);
        default:  rd_data_d = rd_data_q;
      endcase
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // statistics and read-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= CNT_ZERO;
      last_q    <= CNT_ZERO;
      min_q     <= CNT_ONES;
      max_q     <= CNT_ZERO;
      pcnt_q    <= {PCNT_W{1'b0}};
      ovf_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= CNT_ZERO;
    end else begin
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
      pcnt_q    <= pcnt_d;
      ovf_q     <= ovf_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign pulse_det  = det_s;
  assign pulse_cnt  = pcnt_q;
  assign overflow   = ovf_q;
  assign rd.rd_ack  = rd_ack_q;
  assign rd.rd_data = rd_data_q;

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Scoreboard bench for pulse_interval_monitor: a 16-bit instance for the main
// tests and a 4-bit instance for interval saturation.
module tb_pulse_interval_monitor;

  import pulse_mon_pkg::*;

  logic clk;
  logic rst;
  logic pulse_in_m, clear_m, pulse_det_m, overflow_m;
  logic pulse_in_s, clear_s, pulse_det_s, overflow_s;
  logic [7:0] pulse_cnt_m, pulse_cnt_s;

  int checks;
  int errors;

  logic [15:0] exp_m[$];
  logic [3:0]  exp_s[$];

  pulse_interval_monitor_if #(.CNT_W(16)) rd_m ();
  pulse_interval_monitor_if #(.CNT_W(4))  rd_s ();

  pulse_interval_monitor #(.CNT_W(16), .SYNC_STAGES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in_m),
    .clear     (clear_m),
    .rd        (rd_m),
    .pulse_det (pulse_det_m),
    .pulse_cnt (pulse_cnt_m),
    .overflow  (overflow_m)
  );

  pulse_interval_monitor #(.CNT_W(4), .SYNC_STAGES(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in_s),
    .clear     (clear_s),
    .rd        (rd_s),
    .pulse_det (pulse_det_s),
    .pulse_cnt (pulse_cnt_s),
    .overflow  (overflow_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one-cycle-high pulse; consumes one clock edge
  task automatic rise1(input bit sat);
    if (sat) pulse_in_s = 1'b1; else pulse_in_m = 1'b1;
    step();
    if (sat) pulse_in_s = 1'b0; else pulse_in_m = 1'b0;
  endtask

  task automatic rd_main(input logic [1:0] sel, input logic [15:0] exp);
    rd_m.rd_req = 1'b1;
    rd_m.rd_sel = sel;
    exp_m.push_back(exp);
    step();
    rd_m.rd_req = 1'b0;
  endtask

  task automatic rd_sat(input logic [1:0] sel, input logic [3:0] exp);
    rd_s.rd_req = 1'b1;
    rd_s.rd_sel = sel;
    exp_s.push_back(exp);
    step();
    rd_s.rd_req = 1'b0;
  endtask

  // scoreboard monitors: pop and compare whenever an ack is presented
  always @(negedge clk) begin
    if (rd_m.rd_ack === 1'b1) begin
      if (exp_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_main_unexpected: got ack data=%0h expected no ack", rd_m.rd_data);
      end else begin
        chk("rd_main", {16'h0, rd_m.rd_data}, {16'h0, exp_m.pop_front()});
      end
    end
    if (rd_s.rd_ack === 1'b1) begin
      if (exp_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_sat_unexpected: got ack data=%0h expected no ack", rd_s.rd_data);
      end else begin
        chk("rd_sat", {28'h0, rd_s.rd_data}, {28'h0, exp_s.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int ndet;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pulse_in_m = 1'b0; clear_m = 1'b0;
    pulse_in_s = 1'b0; clear_s = 1'b0;
    rd_m.rd_req = 1'b0; rd_m.rd_sel = 2'd0;
    rd_s.rd_req = 1'b0; rd_s.rd_sel = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // latency and one-shot: pin held high for 7 cycles
    lat = 0;
    ndet = 0;
    pulse_in_m = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pulse_det_m === 1'b1) begin
        ndet++;
        if (lat == 0) lat = i;
      end
      if (i == 7) pulse_in_m = 1'b0;
    end
    chk("det_latency", lat, 3);
    chk("det_count", ndet, 1);
    chk("cnt_after_first", {24'h0, pulse_cnt_m}, 32'd1);
    rd_main(SEL_LAST, 16'h0000);
    rd_main(SEL_MIN, 16'hFFFF);
    step();

    // asynchronous reset in the middle of a read request
    rd_m.rd_req = 1'b1;
    rd_m.rd_sel = SEL_MIN;
    #2 rst = 1'b1;
    #1;
    chk("rst_pulse_det", {31'h0, pulse_det_m}, 32'd0);
    chk("rst_pulse_cnt", {24'h0, pulse_cnt_m}, 32'd0);
    chk("rst_overflow", {31'h0, overflow_m}, 32'd0);
    chk("rst_rd_ack", {31'h0, rd_m.rd_ack}, 32'd0);
    chk("rst_rd_data", {16'h0, rd_m.rd_data}, 32'd0);
    rd_m.rd_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    rd_main(SEL_MIN, 16'hFFFF);

    // interval statistics: spacings 10, 4, 25
    rise1(1'b0); repeat (9) step();
    rise1(1'b0); repeat (3) step();
    rise1(1'b0); repeat (24) step();
    rise1(1'b0); repeat (6) step();
    rd_main(SEL_LAST, 16'd25);
    rd_main(SEL_MIN, 16'd4);
    rd_main(SEL_MAX, 16'd25);
    chk("cnt_stats", {24'h0, pulse_cnt_m}, 32'd4);

    // clear alone, then clear coincident with pulse_det
    clear_m = 1'b1; step(); clear_m = 1'b0;
    chk("cnt_clear", {24'h0, pulse_cnt_m}, 32'd0);
    rd_main(SEL_MAX, 16'd0);
    rise1(1'b0); step(); step();
    chk("det_vs_clear", {31'h0, pulse_det_m}, 32'd1);
    clear_m = 1'b1; step(); clear_m = 1'b0;
    repeat (4) step();
    chk("cnt_clear_wins", {24'h0, pulse_cnt_m}, 32'd0);

    // read coincident with an update of last from 10 to 6
    rise1(1'b0); repeat (9) step();
    rise1(1'b0); repeat (5) step();
    rise1(1'b0); step(); step();
    chk("det_vs_read", {31'h0, pulse_det_m}, 32'd1);
    rd_main(SEL_LAST, 16'd10);
    rd_main(SEL_LAST, 16'd6);
    repeat (4) step();
    chk("cnt_collide", {24'h0, pulse_cnt_m}, 32'd3);

    // pulse count wrap: 257 pulses spaced 3 cycles
    clear_m = 1'b1; step(); clear_m = 1'b0;
    for (int i = 0; i < 257; i++) begin
      rise1(1'b0);
      repeat (2) step();
    end
    repeat (6) step();
    chk("cnt_wrap", {24'h0, pulse_cnt_m}, 32'd1);
    chk("ovf_main", {31'h0, overflow_m}, 32'd0);
    rd_main(SEL_STAT, 16'h0001);
    rd_main(SEL_MIN, 16'd3);
    rd_main(SEL_MAX, 16'd3);

    // saturation on the 4-bit instance: rises 40 cycles apart
    rise1(1'b1); repeat (39) step();
    rise1(1'b1); repeat (6) step();
    rd_sat(SEL_LAST, 4'hF);
    rd_sat(SEL_STAT, 4'hA);
    chk("ovf_sat", {31'h0, overflow_s}, 32'd1);
    chk("cnt_sat", {24'h0, pulse_cnt_s}, 32'd2);
    clear_s = 1'b1; step(); clear_s = 1'b0;
    chk("ovf_sat_clear", {31'h0, overflow_s}, 32'd0);
    chk("cnt_sat_clear", {24'h0, pulse_cnt_s}, 32'd0);
    rise1(1'b1); step(); step();
    chk("det_sat", {31'h0, pulse_det_s}, 32'd1);
    repeat (4) step();
    rd_sat(SEL_LAST, 4'h0);
    rd_sat(SEL_MAX, 4'h0);
    chk("cnt_sat_idle", {24'h0, pulse_cnt_s}, 32'd1);

    repeat (5) step();
    chk("sb_main_drained", exp_m.size(), 0);
    chk("sb_sat_drained", exp_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
